// File: rtl/approx_mul_seq.sv
// Sequential shift-add multiplier with an approximate mode that skips the K
// low multiplier bits, trading accuracy for W-K instead of W iteration cycles.
module approx_mul_seq #(
    parameter int W = 8,
    parameter int K = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             out_approx,
    output logic             busy
);

    if (W < 2 || W > 32 || K < 0 || K > W - 1) begin : g_param_check
        $error("approx_mul_seq: illegal parameters W=%0d K=%0d", W, K);
    end

    localparam int            IW   = $clog2(W) + 1;
    localparam logic [IW-1:0] LAST = IW'(W - 1);
    localparam logic [IW-1:0] KIDX = IW'(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              mode_q, mode_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic [2*W-1:0]    p_q, p_d;
    logic              pa_q, pa_d;

    logic [W-1:0]      b_sh;
    logic [2*W-1:0]    a_ext;
    logic [2*W-1:0]    partial;

    assign b_sh    = b_q >> idx_q;
    assign a_ext   = {{W{1'b0}}, a_q};
    assign partial = b_sh[0] ? (a_ext << idx_q) : '0;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        p_d     = p_q;
        pa_d    = pa_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    mode_d  = in_approx;
                    acc_d   = '0;
                    idx_d   = in_approx ? KIDX : '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // A*B < 2^(2W), so the running sum always fits the accumulator.
                acc_d = acc_q + partial;
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    p_d     = acc_d;
                    pa_d    = mode_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            pa_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            pa_q    <= pa_d;
        end
    end

    // Operand registers only matter once loaded by an accept.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        mode_q <= mode_d;
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_p      = p_q;
    assign out_approx = pa_q;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Bench for approx_mul_seq: three instances, (W,K) = (8,0), (8,2), (16,5),
// driven from one shared stimulus set and checked against an arithmetic model.
module tb_approx_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a, in_b;
    logic        in_approx;
    logic        out_ready;
    int          sel;
    int          cyc = 0;
    int          vec = 0;
    int          miss = 0;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2, oa0, oa1, oa2, bz0, bz1, bz2;
    logic [15:0] op0, op1;
    logic [31:0] op2;

    logic        irs, ovs, oas, busys;
    logic [31:0] ops;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    approx_mul_seq #(.W(8), .K(0)) u_80 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_approx(in_approx),
        .out_valid(ov0), .out_ready(out_ready), .out_p(op0),
        .out_approx(oa0), .busy(bz0));

    approx_mul_seq #(.W(8), .K(2)) u_82 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_approx(in_approx),
        .out_valid(ov1), .out_ready(out_ready), .out_p(op1),
        .out_approx(oa1), .busy(bz1));

    approx_mul_seq #(.W(16), .K(5)) u_165 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(ov2), .out_ready(out_ready), .out_p(op2),
        .out_approx(oa2), .busy(bz2));

    always_comb begin
        irs = ir0; ovs = ov0; oas = oa0; busys = bz0; ops = {16'd0, op0};
        if (sel == 1) begin
            irs = ir1; ovs = ov1; oas = oa1; busys = bz1; ops = {16'd0, op1};
        end else if (sel == 2) begin
            irs = ir2; ovs = ov2; oas = oa2; busys = bz2; ops = op2;
        end
    end

    // Drives one operation from IDLE to the completed handshake. Reports product,
    // accept-to-valid latency, mode echo, protocol health and the accept cycle.
    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                          input bit m, input int stall,
                          output longint unsigned p, output int lat, output bit pa,
                          output bit ok, output int acc_cyc);
        ok = 1'b1;
        lat = -1;
        p = 0;
        pa = 1'b0;
        sel = s;
        if (!irs) ok = 1'b0;
        in_a = a; in_b = b; in_approx = m; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_a = 16'($urandom); in_b = 16'($urandom); in_approx = 1'($urandom);
        in_valid = 1'($urandom);
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (ovs) begin
                lat = c;
                break;
            end
            if (irs || !busys) ok = 1'b0;
            out_ready = 1'($urandom);
            in_a = 16'($urandom); in_b = 16'($urandom); in_approx = 1'($urandom);
        end
        out_ready = 1'b0;
        p = longint'(ops);
        pa = oas;
        for (int i = 0; i < stall; i++) begin
            in_a = 16'($urandom); in_b = 16'($urandom); in_approx = 1'($urandom);
            @(posedge clk); #1;
            if (!ovs || irs || longint'(ops) != p || oas != pa) ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (ovs || !irs || busys) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1;
        in_a = '0; in_b = '0; in_approx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            vec++;
            if (irs !== 1'b1 || ovs !== 1'b0 || ops !== 32'd0 || oas !== 1'b0 || busys !== 1'b0) begin
                miss++;
                $display("FAIL reset inst%0d: got rdy=%b vld=%b p=%0d pa=%b busy=%b, need 1 0 0 0 0",
                         s, irs, ovs, ops, oas, busys);
            end
        end
    endtask

    task automatic test_vectors();
        logic [15:0] ta [4] = '{16'd255, 16'd255, 16'd13, 16'd13};
        logic [15:0] tb [4] = '{16'd255, 16'd255, 16'd3, 16'd7};
        bit          tm [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        longint unsigned ep [4] = '{65025, 64260, 0, 52};
        int          el [4] = '{8, 6, 6, 6};
        longint unsigned p; int lat; bit pa, ok; int ac;
        for (int i = 0; i < 4; i++) begin
            run_op(1, ta[i], tb[i], tm[i], 1, p, lat, pa, ok, ac);
            vec++;
            if (p !== ep[i] || pa !== tm[i]) begin
                miss++;
                $display("FAIL vector%0d product: got %0d/%b need %0d/%b", i, p, pa, ep[i], tm[i]);
            end
            vec++;
            if (lat !== el[i] || !ok) begin
                miss++;
                $display("FAIL vector%0d latency: got %0d ok=%b need %0d ok=1", i, lat, ok, el[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        longint unsigned p; int lat; bit pa, ok; int ac;
        run_op(1, 16'd100, 16'd201, 1'b0, 5, p, lat, pa, ok, ac);
        vec++;
        if (p !== 64'd20100 || !ok) begin
            miss++;
            $display("FAIL backpressure: got p=%0d ok=%b need 20100 ok=1", p, ok);
        end
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (ovs !== 1'b0 || irs !== 1'b1 || ops !== 32'd20100) begin
            miss++;
            $display("FAIL bp_idle: got vld=%b rdy=%b p=%0d need 0 1 20100", ovs, irs, ops);
        end
    endtask

    task automatic test_reset_mid();
        longint unsigned p; int lat; bit pa, ok, seen; int ac;
        sel = 1;
        in_a = 16'd200; in_b = 16'd100; in_approx = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vec++;
        if (irs !== 1'b1 || ovs !== 1'b0 || ops !== 32'd0 || busys !== 1'b0) begin
            miss++;
            $display("FAIL reset_mid: got rdy=%b vld=%b p=%0d busy=%b need 1 0 0 0", irs, ovs, ops, busys);
        end
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (ovs) seen = 1'b1; end
        vec++;
        if (seen !== 1'b0) begin
            miss++;
            $display("FAIL reset_discard: got out_valid pulse=%b need 0", seen);
        end
        run_op(1, 16'd7, 16'd9, 1'b0, 0, p, lat, pa, ok, ac);
        vec++;
        if (p !== 64'd63 || lat !== 8 || !ok) begin
            miss++;
            $display("FAIL after_reset 7*9: got %0d lat %0d ok=%b need 63 lat 8", p, lat, ok);
        end
    endtask

    task automatic test_k0();
        longint unsigned pe, pp; int le, lp; bit ae, ap, oke, okp; int ac;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
            run_op(0, a, b, 1'b0, 0, pe, le, ae, oke, ac);
            run_op(0, a, b, 1'b1, 0, pp, lp, ap, okp, ac);
            vec++;
            if (pe !== longint'(a) * longint'(b) || pp !== pe || lp !== le || le !== 8 ||
                ae !== 1'b0 || ap !== 1'b1 || !oke || !okp) begin
                miss++;
                $display("FAIL k0 %0d*%0d: got exact %0d/%0d approx %0d/%0d flags %b%b need %0d lat 8 flags 01",
                         a, b, pe, le, pp, lp, ae, ap, longint'(a) * longint'(b));
            end
        end
    endtask

    task automatic test_back_to_back();
        longint unsigned p; int lat; bit pa, ok; int c0, c1, c2;
        run_op(2, 16'd1000, 16'd999, 1'b1, 0, p, lat, pa, ok, c0);
        run_op(2, 16'd65535, 16'd65535, 1'b0, 0, p, lat, pa, ok, c1);
        run_op(2, 16'd3, 16'd31, 1'b1, 0, p, lat, pa, ok, c2);
        vec++;
        if (c1 - c0 !== 11 + 2 || c2 - c1 !== 16 + 2) begin
            miss++;
            $display("FAIL back_to_back spacing: got %0d,%0d need 13,18", c1 - c0, c2 - c1);
        end
        vec++;
        if (p !== 64'd0) begin
            miss++;
            $display("FAIL back_to_back 3*31 approx: got %0d need 0", p);
        end
    endtask

    task automatic test_random(input int s, input int w, input int k, input int nops);
        longint unsigned a, b, eb, ep, p, mask;
        int lat, el, ac, gap;
        bit m, pa, ok;
        mask = (64'd1 << w) - 1;
        for (int n = 0; n < nops; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                in_a = 16'($urandom); in_b = 16'($urandom);
                @(posedge clk); #1;
            end
            a = longint'($urandom) & mask;
            b = longint'($urandom) & mask;
            m = 1'($urandom);
            run_op(s, a[15:0], b[15:0], m, $urandom_range(0, 2), p, lat, pa, ok, ac);
            eb = m ? (b & ~((64'd1 << k) - 1)) : b;
            ep = a * eb;
            el = m ? w - k : w;
            vec++;
            if (p !== ep || pa !== m) begin
                miss++;
                $display("FAIL rand W%0d K%0d %0d*%0d m=%b: got %0d/%b need %0d", w, k, a, b, m, p, pa, ep);
            end
            vec++;
            if (lat !== el || !ok) begin
                miss++;
                $display("FAIL rand_lat W%0d K%0d m=%b: got %0d ok=%b need %0d ok=1", w, k, m, lat, ok, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_k0();
        test_back_to_back();
        test_random(0, 8, 0, 1000);
        test_random(1, 8, 2, 1000);
        test_random(2, 16, 5, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
